// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen
// Parametrised VGA raster timing generator driven by a system clock plus a
// pixel clock-enable. Counters advance only on pix_ce_vga; every output is
// registered and decoded from the next-state counters, so the outputs always
// describe the counter position that is being entered.
//
// Optional feature: define VGA_TIMING_LINE_MATCH_EN to add the match_line_vga
// input and the line_match_vga strobe (fires on the line start of a chosen
// line).
module vga_timing_gen #(
  parameter int H_VIZ   = 640,
  parameter int H_FP    = 16,
  parameter int H_PULSE = 96,
  parameter int H_BP    = 48,
  parameter int V_VIZ   = 480,
  parameter int V_FP    = 10,
  parameter int V_PULSE = 2,
  parameter int V_BP    = 33,
  parameter int H_POL   = 0,
  parameter int V_POL   = 0,
  parameter int CNT_W   = 10
) (
  input  logic             clk_vga,
  input  logic             rst_vga,
  input  logic             pix_ce_vga,
  output logic             h_out_vga,
  output logic             v_out_vga,
  output logic             active_vga,
  output logic [CNT_W-1:0] horizontal_x_vga,
  output logic [CNT_W-1:0] vertical_y_vga,
  output logic             frame_start_vga,
  output logic             line_start_vga
`ifdef VGA_TIMING_LINE_MATCH_EN
  ,
  input  logic [CNT_W-1:0] match_line_vga,
  output logic             line_match_vga
`endif
);

  localparam int H_TOTAL = H_VIZ + H_FP + H_PULSE + H_BP;
  localparam int V_TOTAL = V_VIZ + V_FP + V_PULSE + V_BP;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Last counter values and region boundaries, all at counter width.
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIZ_C  = CNT_W'(H_VIZ);
  localparam logic [CNT_W-1:0] V_VIZ_C  = CNT_W'(V_VIZ);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VIZ + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VIZ + H_FP + H_PULSE - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VIZ + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VIZ + V_FP + V_PULSE - 1);

  // Active levels of the sync outputs.
  localparam logic HS_ON = (H_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VS_ON = (V_POL != 0) ? 1'b1 : 1'b0;

  logic [CNT_W-1:0] h_cnt_r;
  logic [CNT_W-1:0] v_cnt_r;
  logic [CNT_W-1:0] h_nxt_s;
  logic [CNT_W-1:0] v_nxt_s;
  logic             v_viz_s;
  logic             hs_nxt_s;
  logic             vs_nxt_s;
  logic             act_nxt_s;
  logic [CNT_W-1:0] x_nxt_s;
  logic [CNT_W-1:0] y_nxt_s;
  logic             ls_nxt_s;
  logic             fs_nxt_s;

  // Next raster position: h steps on each enable, v steps on the h wrap.
  always_comb begin
    h_nxt_s = h_cnt_r;
    v_nxt_s = v_cnt_r;
    if (pix_ce_vga) begin
      if (h_cnt_r == H_LAST) begin
        h_nxt_s = CNT_ZERO;
        if (v_cnt_r == V_LAST) begin
          v_nxt_s = CNT_ZERO;
        end else begin
          v_nxt_s = v_cnt_r + CNT_ONE;
        end
      end else begin
        h_nxt_s = h_cnt_r + CNT_ONE;
        v_nxt_s = v_cnt_r;
      end
    end else begin
      h_nxt_s = h_cnt_r;
      v_nxt_s = v_cnt_r;
    end
  end

  // Decode the position being entered into the registered output values.
  always_comb begin
    v_viz_s   = (v_nxt_s < V_VIZ_C);
    act_nxt_s = (h_nxt_s < H_VIZ_C) && v_viz_s;
    x_nxt_s   = act_nxt_s ? h_nxt_s : CNT_ZERO;
    y_nxt_s   = v_viz_s ? v_nxt_s : CNT_ZERO;
    hs_nxt_s  = ((h_nxt_s >= HS_FIRST) && (h_nxt_s <= HS_LAST)) ? HS_ON : ~HS_ON;
    // v only moves on the h wrap, so vsync can only change there too.
    vs_nxt_s  = ((v_nxt_s >= VS_FIRST) && (v_nxt_s <= VS_LAST)) ? VS_ON : ~VS_ON;
    // Strobes require an actual advance so they are one clk wide at any rate.
    ls_nxt_s  = pix_ce_vga && (h_nxt_s == CNT_ZERO);
    fs_nxt_s  = ls_nxt_s && (v_nxt_s == CNT_ZERO);
  end

  // Counter and output registers; reset parks on the last back-porch pixel.
  always_ff @(posedge clk_vga) begin
    if (rst_vga) begin
      h_cnt_r          <= H_LAST;
      v_cnt_r          <= V_LAST;
      h_out_vga        <= ~HS_ON;
      v_out_vga        <= ~VS_ON;
      active_vga       <= 1'b0;
      horizontal_x_vga <= CNT_ZERO;
      vertical_y_vga   <= CNT_ZERO;
      frame_start_vga  <= 1'b0;
      line_start_vga   <= 1'b0;
    end else begin
      h_cnt_r          <= h_nxt_s;
      v_cnt_r          <= v_nxt_s;
      h_out_vga        <= hs_nxt_s;
      v_out_vga        <= vs_nxt_s;
      active_vga       <= act_nxt_s;
      horizontal_x_vga <= x_nxt_s;
      vertical_y_vga   <= y_nxt_s;
      frame_start_vga  <= fs_nxt_s;
      line_start_vga   <= ls_nxt_s;
    end
  end

`ifdef VGA_TIMING_LINE_MATCH_EN
  logic lm_nxt_s;

  // Compare the requested line only at a line-start advance; v never reaches
  // V_TOTAL, so larger request values can never match.
  always_comb begin
    lm_nxt_s = ls_nxt_s && (v_nxt_s == match_line_vga);
  end

  // Line-match strobe register.
  always_ff @(posedge clk_vga) begin
    if (rst_vga) begin
      line_match_vga <= 1'b0;
    end else begin
      line_match_vga <= lm_nxt_s;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Testbench for vga_timing_gen: three instances (default 640x480, tall-line
// inverted-polarity mode, tiny mode) share clock, reset and pixel enable.
// A behavioural model queues the expected outputs when stimulus is driven;
// they are popped and compared after the clock edge.
module tb_vga_timing_gen;

  typedef struct {
    int hviz, hfp, hp, hbp, vviz, vfp, vp, vbp;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    int h;
    int v;
  } pos_t;

`ifdef VGA_TIMING_LINE_MATCH_EN
  localparam bit MATCH_EN = 1'b1;
`else
  localparam bit MATCH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_vga;
  logic pix_ce;

  logic       d_hs, d_vs, d_act, d_fs, d_ls, d_lm;
  logic [9:0] d_x, d_y, ml_def;
  logic       p_hs, p_vs, p_act, p_fs, p_ls, p_lm;
  logic [9:0] p_x, p_y, ml_pol;
  logic       s_hs, s_vs, s_act, s_fs, s_ls, s_lm;
  logic [3:0] s_x, s_y, ml_small;

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .clk_vga(clk), .rst_vga(rst_vga), .pix_ce_vga(pix_ce),
    .h_out_vga(d_hs), .v_out_vga(d_vs), .active_vga(d_act),
    .horizontal_x_vga(d_x), .vertical_y_vga(d_y),
    .frame_start_vga(d_fs), .line_start_vga(d_ls)
`ifdef VGA_TIMING_LINE_MATCH_EN
    , .match_line_vga(ml_def), .line_match_vga(d_lm)
`endif
  );

  vga_timing_gen #(
    .V_VIZ(4), .V_FP(2), .V_PULSE(2), .V_BP(1), .H_POL(1), .V_POL(1), .CNT_W(10)
  ) u_pol (
    .clk_vga(clk), .rst_vga(rst_vga), .pix_ce_vga(pix_ce),
    .h_out_vga(p_hs), .v_out_vga(p_vs), .active_vga(p_act),
    .horizontal_x_vga(p_x), .vertical_y_vga(p_y),
    .frame_start_vga(p_fs), .line_start_vga(p_ls)
`ifdef VGA_TIMING_LINE_MATCH_EN
    , .match_line_vga(ml_pol), .line_match_vga(p_lm)
`endif
  );

  vga_timing_gen #(
    .H_VIZ(4), .H_FP(1), .H_PULSE(2), .H_BP(1),
    .V_VIZ(3), .V_FP(1), .V_PULSE(1), .V_BP(1), .CNT_W(4)
  ) u_small (
    .clk_vga(clk), .rst_vga(rst_vga), .pix_ce_vga(pix_ce),
    .h_out_vga(s_hs), .v_out_vga(s_vs), .active_vga(s_act),
    .horizontal_x_vga(s_x), .vertical_y_vga(s_y),
    .frame_start_vga(s_fs), .line_start_vga(s_ls)
`ifdef VGA_TIMING_LINE_MATCH_EN
    , .match_line_vga(ml_small), .line_match_vga(s_lm)
`endif
  );

`ifndef VGA_TIMING_LINE_MATCH_EN
  assign d_lm = 1'b0;
  assign p_lm = 1'b0;
  assign s_lm = 1'b0;
`endif

  cfg_t cfg_def, cfg_pol, cfg_small;
  pos_t m_def, m_pol, m_sm;
  logic [39:0] q_def[$];
  logic [39:0] q_pol[$];
  logic [39:0] q_sm[$];

  int checks = 0;
  int errors = 0;
  int t = 0;

  // measurement state
  bit meas = 1'b0;
  int line_per, pol_frame_per, sm_frame_per, hs_w, vs_w;
  int last_ls_def, last_fs_pol, last_fs_sm, last_lm_sm;
  bit arm_hs, arm_vs;
  int len_hs, len_vs;
  int cnt_lm_def, cnt_lm_pol, cnt_lm_sm;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic bit cfg_ok(input cfg_t c);
    return (c.hviz >= 1) && (c.hfp >= 1) && (c.hp >= 1) && (c.hbp >= 1) &&
           (c.vviz >= 1) && (c.vfp >= 1) && (c.vp >= 1) && (c.vbp >= 1);
  endfunction

  function automatic pos_t advance(input cfg_t c, input pos_t p, input bit rst, input bit ce);
    pos_t n = p;
    int ht = c.hviz + c.hfp + c.hp + c.hbp;
    int vt = c.vviz + c.vfp + c.vp + c.vbp;
    if (rst) begin
      n.h = ht - 1;
      n.v = vt - 1;
    end else if (ce) begin
      n.h = p.h + 1;
      if (n.h == ht) begin
        n.h = 0;
        n.v = p.v + 1;
        if (n.v == vt) n.v = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [39:0] expect_out(input cfg_t c, input pos_t p, input bit adv, input int ml);
    bit hs, vs, act, ls, fs, lm, hit;
    int x, y;
    hs  = (p.h >= c.hviz + c.hfp && p.h < c.hviz + c.hfp + c.hp) ? c.hpol : !c.hpol;
    vs  = (p.v >= c.vviz + c.vfp && p.v < c.vviz + c.vfp + c.vp) ? c.vpol : !c.vpol;
    act = (p.h < c.hviz) && (p.v < c.vviz);
    x   = act ? p.h : 0;
    y   = (p.v < c.vviz) ? p.v : 0;
    ls  = adv && (p.h == 0);
    fs  = ls && (p.v == 0);
    hit = (p.v == ml);
    lm  = MATCH_EN && ls && hit;
    return {fs, ls, lm, hs, vs, act, 2'b00, 16'(x), 16'(y)};
  endfunction

  task automatic monitor();
    if (d_lm) cnt_lm_def++;
    if (p_lm) cnt_lm_pol++;
    if (s_lm) cnt_lm_sm++;
    if (!meas) return;
    if (d_ls) begin
      if (last_ls_def >= 0) check("def_line_per", 40'(t - last_ls_def), 40'(line_per));
      last_ls_def = t;
    end
    if (p_fs) begin
      if (last_fs_pol >= 0) check("pol_frame_per", 40'(t - last_fs_pol), 40'(pol_frame_per));
      last_fs_pol = t;
    end
    if (s_fs) begin
      if (last_fs_sm >= 0) check("sm_frame_per", 40'(t - last_fs_sm), 40'(sm_frame_per));
      last_fs_sm = t;
    end
    if (s_lm) begin
      if (last_lm_sm >= 0) check("sm_match_per", 40'(t - last_lm_sm), 40'(sm_frame_per));
      last_lm_sm = t;
    end
    // default hsync is active-low
    if (d_hs) begin
      if (arm_hs && len_hs > 0) check("def_hs_width", 40'(len_hs), 40'(hs_w));
      arm_hs = 1'b1;
      len_hs = 0;
    end else if (arm_hs) begin
      len_hs++;
    end
    // pol-mode vsync is active-high
    if (!p_vs) begin
      if (arm_vs && len_vs > 0) check("pol_vs_width", 40'(len_vs), 40'(vs_w));
      arm_vs = 1'b1;
      len_vs = 0;
    end else if (arm_vs) begin
      len_vs++;
    end
  endtask

  task automatic meas_start(input int lp, input int pf, input int sf, input int hw, input int vw);
    meas = 1'b1;
    line_per = lp; pol_frame_per = pf; sm_frame_per = sf; hs_w = hw; vs_w = vw;
    last_ls_def = -1; last_fs_pol = -1; last_fs_sm = -1; last_lm_sm = -1;
    arm_hs = 1'b0; arm_vs = 1'b0; len_hs = 0; len_vs = 0;
    cnt_lm_def = 0; cnt_lm_pol = 0; cnt_lm_sm = 0;
  endtask

  task automatic cycle(input bit rst, input bit ce);
    @(negedge clk);
    rst_vga = rst;
    pix_ce  = ce;
    m_def = advance(cfg_def, m_def, rst, ce);
    q_def.push_back(expect_out(cfg_def, m_def, ce && !rst, int'(ml_def)));
    m_pol = advance(cfg_pol, m_pol, rst, ce);
    q_pol.push_back(expect_out(cfg_pol, m_pol, ce && !rst, int'(ml_pol)));
    m_sm = advance(cfg_small, m_sm, rst, ce);
    q_sm.push_back(expect_out(cfg_small, m_sm, ce && !rst, int'(ml_small)));
    @(posedge clk);
    #1;
    t++;
    check("def", {d_fs, d_ls, d_lm, d_hs, d_vs, d_act, 2'b00, 6'b0, d_x, 6'b0, d_y}, q_def.pop_front());
    check("pol", {p_fs, p_ls, p_lm, p_hs, p_vs, p_act, 2'b00, 6'b0, p_x, 6'b0, p_y}, q_pol.pop_front());
    check("small", {s_fs, s_ls, s_lm, s_hs, s_vs, s_act, 2'b00, 12'b0, s_x, 12'b0, s_y}, q_sm.pop_front());
    monitor();
  endtask

  initial begin
    bit changed;
    cfg_def   = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg_pol   = '{640, 16, 96, 48, 4, 2, 2, 1, 1'b1, 1'b1};
    cfg_small = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0};
    if (!cfg_ok(cfg_def) || !cfg_ok(cfg_pol) || !cfg_ok(cfg_small)) begin
      $display("FAIL params: a porch, pulse or visible size is below 1");
      $fatal(1, "bad parameters");
    end
    m_def = '{0, 0}; m_pol = '{0, 0}; m_sm = '{0, 0};
    rst_vga = 1'b1; pix_ce = 1'b0;
    ml_def = 10'd2; ml_pol = 10'd2; ml_small = 4'd2;

    // Reset with enable high: reset must win.
    repeat (3) cycle(1'b1, 1'b1);

    // Phase A: enable every clock.
    meas_start(800, 7200, 48, 96, 1600);
    cycle(1'b0, 1'b1);
    check("first_after_reset", {d_fs, d_ls, d_lm, d_hs, d_vs, d_act, 2'b00, 6'b0, d_x, 6'b0, d_y},
          {6'b110111, 34'b0});
    for (int i = 0; i < 7500; i++) cycle(1'b0, 1'b1);
`ifdef VGA_TIMING_LINE_MATCH_EN
    check("def_match_cnt_A", 40'(cnt_lm_def), 40'd1);
    check("pol_match_cnt_A", 40'(cnt_lm_pol), 40'd1);
`endif

    // Phase B: enable every second clock, restart from reset.
    ml_def = 10'd600; ml_pol = 10'd7; ml_small = 4'd10;
    cycle(1'b1, 1'b1);
    meas_start(1600, 14400, 96, 192, 3200);
    changed = 1'b0;
    for (int i = 0; i < 16500; i++) begin
      // move the pol-mode match target while inside line 3
      if (!changed && m_pol.v == 3) begin
        ml_pol = 10'd1;
        changed = 1'b1;
      end
      cycle(1'b0, (i % 2) == 0);
    end
`ifdef VGA_TIMING_LINE_MATCH_EN
    check("def_match_cnt_B", 40'(cnt_lm_def), 40'd0);
    check("pol_match_cnt_B", 40'(cnt_lm_pol), 40'd1);
    check("sm_match_cnt_B", 40'(cnt_lm_sm), 40'd0);
`endif

    // Phase C: mid-frame reset pulse at line 2, h=300 of the default mode.
    meas = 1'b0;
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 1901; i++) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    check("def_mid_reset", {d_fs, d_ls, d_lm, d_hs, d_vs, d_act, 2'b00, 6'b0, d_x, 6'b0, d_y},
          {6'b000110, 34'b0});
    check("pol_mid_reset", {p_fs, p_ls, p_lm, p_hs, p_vs, p_act, 2'b00, 6'b0, p_x, 6'b0, p_y}, 40'b0);
    repeat (3) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    check("def_restart", {d_fs, d_ls, d_lm, d_hs, d_vs, d_act, 2'b00, 6'b0, d_x, 6'b0, d_y},
          {6'b110111, 34'b0});

    // Phase D: irregular enable and changing match targets.
    for (int i = 0; i < 3000; i++) begin
      if ((i % 97) == 0) ml_small = 4'($urandom_range(0, 7));
      cycle(1'b0, $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
